mem_store_unit: RTL and testbench
=================================

Name: mem_store_unit

Overview:
- MEM-stage store issuer; the write-side counterpart of the WB load-data extraction.
- Takes a store op (SB/SH/SW/SWL/SWR) and computes byte strobes plus lane-aligned write data.
- Detects address-error-on-store (AdES).
- Drives the data-side SRAM-like bus: req/addr_ok then data_ok, with the pipeline stalled until the write completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, four byte lanes.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- store_valid_i  input  1  MEM stage holds a valid store; inputs stay stable while stall_o=1
- aluop_i  input  8  `ALUOP_SB/SH/SW/SWL/SWR from defines.vh; other values are not stores
- mem_addr_i  input  32  effective byte address
- rt_data_i  input  32  store source register
- exc_flush_i  input  1  pipeline flush (exception/eret in older stage)
- pipe_adv_i  input  1  MEM stage advances at this edge
- data_req  output  1  bus request
- data_wr  output  1  1 = write; equals data_req
- data_size  output  2  0 = byte, 1 = half, 2 = word
- data_addr  output  32  bus address
- data_wstrb  output  4  byte enables, bit k = lane k (little-endian)
- data_wdata  output  32  lane-aligned write data
- data_addr_ok  input  1  request accepted this cycle
- data_data_ok  input  1  write completed this cycle
- ades_o  output  1  misaligned store, combinational
- stall_o  output  1  hold the pipeline

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE; all outputs 0.
- Legal store: store_valid_i & aluop is a store & !ades_o & !exc_flush_i.
- ades_o = store_valid_i & ((SH & addr[0]) | (SW & addr[1:0]!=0)). No request is issued; no stall. SWL/SWR never fault.
- Lane mapping, a = addr[1:0]:
  - SB: wstrb = 1<<a; wdata = {4{rt[7:0]}}; size 0; addr unchanged.
  - SH: wstrb = a[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}; size 1.
  - SW: wstrb 1111; wdata = rt; size 2.
  - SWL: a=00 -> 0001, {24'b0, rt[31:24]}; 01 -> 0011, {16'b0, rt[31:16]}; 10 -> 0111, {8'b0, rt[31:8]}; 11 -> 1111, rt.
  - SWR: a=00 -> 1111, rt; 01 -> 1110, {rt[23:0], 8'b0}; 10 -> 1100, {rt[15:0], 16'b0}; 11 -> 1000, {rt[7:0], 24'b0}.
  - SWL/SWR: size 2; data_addr = {addr[31:2], 2'b00}.
- Bus fields are registered when leaving IDLE and held constant until the request is accepted.
- IDLE:
  - Legal store -> REQ; stall_o=1 combinationally this cycle.
  - Otherwise stay; stall_o=0.
- REQ:
  - data_req=1.
  - addr_ok -> WAIT. This applies even if exc_flush_i is asserted the same cycle: an accepted store must complete.
  - exc_flush_i & !addr_ok -> IDLE; request withdrawn.
  - stall_o=1.
- WAIT:
  - data_req=0.
  - data_ok -> DONE.
  - stall_o=1, except in the data_ok cycle, where it is 0.
  - exc_flush_i ignored.
- DONE:
  - stall_o=0; no new request.
  - pipe_adv_i or exc_flush_i -> IDLE. This prevents re-issuing a store held by an unrelated downstream stall.
- Latency: request visible 1 cycle after store_valid_i; best case stall_o=1 for 2 cycles (addr_ok in the first REQ cycle, data_ok the next).
- data_ok arriving in REQ or IDLE is a protocol error; it is ignored.
- rst in any state -> IDLE next edge; an in-flight bus transaction is abandoned (bus is reset together).

Optional Feature:
- Macro: STORE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_store_cnt[31:0] (increments on each data_ok in WAIT) and perf_stall_cnt[31:0] (increments each cycle stall_o=1).
  - Both are cleared by rst and wrap modulo 2^32.
- Undefined: ports and logic absent; remaining behaviour is identical.

Test Plan:
- SW addr 0x1000_0004, rt 0xDEADBEEF, addr_ok in first REQ cycle, data_ok next -> one req cycle; wstrb 1111, wdata 0xDEADBEEF, size 2; stall_o high exactly 2 cycles.
- SB addr 0x...0003, rt 0x12345678 -> wstrb 1000, wdata 0x78787878, size 0, addr unchanged. SH addr 0x...0002, rt 0xAAAA5555 -> wstrb 1100, wdata 0x55555555.
- SWL addr 0x...0001, rt 0x11223344 -> wstrb 0011, wdata 0x00001122, addr 0x...0000. SWR addr 0x...0002 -> wstrb 1100, wdata 0x33440000.
- SH addr 0x...0001 and SW addr 0x...0002 -> ades_o=1, data_req never asserted, stall_o=0.
- addr_ok held low 3 cycles: req and fields stable. Flush in 2nd REQ cycle -> IDLE, no transaction. Repeat with flush coinciding with addr_ok -> WAIT, waits for data_ok.
- data_ok received with pipe_adv_i low for 4 cycles -> stays DONE, no second req; pipe_adv_i -> IDLE. rst asserted in WAIT -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_store_unit_if.sv
// Data-side SRAM-like write bus between the MEM-stage store issuer (master) and memory (slave).
interface mem_store_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic [DATA_W-1:0]     data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;

   modport master (
      output data_req,
      output data_wr,
      output data_size,
      output data_addr,
      output data_wstrb,
      output data_wdata,
      input  data_addr_ok,
      input  data_data_ok
   );

   modport slave (
      input  data_req,
      input  data_wr,
      input  data_size,
      input  data_addr,
      input  data_wstrb,
      input  data_wdata,
      output data_addr_ok,
      output data_data_ok
   );
endinterface

// File: rtl/mem_store_unit.sv
// MEM-stage store issuer: byte strobes, lane-aligned data, AdES and the req/addr_ok/data_ok write.
// Define STORE_PERF_CNT_EN to add the perf_store_cnt / perf_stall_cnt counters.
module mem_store_unit #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter logic [7:0]  ALUOP_SB  = 8'h28,
   parameter logic [7:0]  ALUOP_SH  = 8'h29,
   parameter logic [7:0]  ALUOP_SWL = 8'h2A,
   parameter logic [7:0]  ALUOP_SW  = 8'h2B,
   parameter logic [7:0]  ALUOP_SWR = 8'h2E
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              store_valid_i,
   input  logic [7:0]        aluop_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       rt_data_i,
   input  logic              exc_flush_i,
   input  logic              pipe_adv_i,
   mem_store_unit_if.master  bus,
   output logic              ades_o,
   output logic              stall_o
`ifdef STORE_PERF_CNT_EN
   ,
   output logic [31:0]       perf_store_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e              r_state;
   logic                r_req;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_wstrb;
   logic [DATA_W-1:0]   r_wdata;

   logic [1:0]          w_a;
   logic                w_is_sb;
   logic                w_is_sh;
   logic                w_is_sw;
   logic                w_is_swl;
   logic                w_is_swr;
   logic                w_is_store;
   logic                w_legal;
   logic [3:0]          w_wstrb;
   logic [DATA_W-1:0]   w_wdata;
   logic [1:0]          w_size;
   logic [ADDR_W-1:0]   w_addr;
   logic [ADDR_W-1:0]   w_addr_al;

   assign w_a        = mem_addr_i[1:0];
   assign w_addr_al  = {mem_addr_i[ADDR_W-1:2], 2'b00};
   assign w_is_sb    = (aluop_i == ALUOP_SB);
   assign w_is_sh    = (aluop_i == ALUOP_SH);
   assign w_is_sw    = (aluop_i == ALUOP_SW);
   assign w_is_swl   = (aluop_i == ALUOP_SWL);
   assign w_is_swr   = (aluop_i == ALUOP_SWR);
   assign w_is_store = w_is_sb | w_is_sh | w_is_sw | w_is_swl | w_is_swr;

   // SWL/SWR are the unaligned-word pair and never raise AdES.
   assign ades_o  = store_valid_i & ((w_is_sh & w_a[0]) | (w_is_sw & (w_a != 2'b00)));
   assign w_legal = store_valid_i & w_is_store & ~ades_o & ~exc_flush_i;

   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = '0;
      w_size  = 2'd2;
      w_addr  = mem_addr_i;
      if (w_is_sb) begin
         w_size  = 2'd0;
         w_wstrb = 4'b0001 << w_a;
         w_wdata = {4{rt_data_i[7:0]}};
      end else if (w_is_sh) begin
         w_size  = 2'd1;
         w_wstrb = w_a[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{rt_data_i[15:0]}};
      end else if (w_is_sw) begin
         w_wstrb = 4'b1111;
         w_wdata = rt_data_i;
      end else if (w_is_swl) begin
         // SWL writes the high-order bytes of rt into the low lanes up to the addressed byte.
         w_addr = w_addr_al;
         case (w_a)
            2'd0: begin w_wstrb = 4'b0001; w_wdata = {24'b0, rt_data_i[31:24]}; end
            2'd1: begin w_wstrb = 4'b0011; w_wdata = {16'b0, rt_data_i[31:16]}; end
            2'd2: begin w_wstrb = 4'b0111; w_wdata = {8'b0, rt_data_i[31:8]};   end
            default: begin w_wstrb = 4'b1111; w_wdata = rt_data_i;              end
         endcase
      end else if (w_is_swr) begin
         w_addr = w_addr_al;
         case (w_a)
            2'd0: begin w_wstrb = 4'b1111; w_wdata = rt_data_i;                 end
            2'd1: begin w_wstrb = 4'b1110; w_wdata = {rt_data_i[23:0], 8'b0};   end
            2'd2: begin w_wstrb = 4'b1100; w_wdata = {rt_data_i[15:0], 16'b0};  end
            default: begin w_wstrb = 4'b1000; w_wdata = {rt_data_i[7:0], 24'b0}; end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_req   <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wstrb <= 4'b0000;
         r_wdata <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_legal) begin
                  r_state <= StReq;
                  r_req   <= 1'b1;
                  r_size  <= w_size;
                  r_addr  <= w_addr;
                  r_wstrb <= w_wstrb;
                  r_wdata <= w_wdata;
               end
            end
            StReq: begin
               // Acceptance wins over a same-cycle flush: the write is already committed.
               if (bus.data_addr_ok) begin
                  r_state <= StWait;
                  r_req   <= 1'b0;
               end else if (exc_flush_i) begin
                  r_state <= StIdle;
                  r_req   <= 1'b0;
               end
            end
            StWait: begin
               if (bus.data_data_ok) begin
                  r_state <= StDone;
               end
            end
            StDone: begin
               if (pipe_adv_i | exc_flush_i) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stall_o = 1'b0;
      case (r_state)
         StIdle:  stall_o = w_legal;
         StReq:   stall_o = 1'b1;
         StWait:  stall_o = ~bus.data_data_ok;
         default: stall_o = 1'b0;
      endcase
   end

   assign bus.data_req   = r_req;
   assign bus.data_wr    = r_req;
   assign bus.data_size  = r_size;
   assign bus.data_addr  = r_addr;
   assign bus.data_wstrb = r_wstrb;
   assign bus.data_wdata = r_wdata;

`ifdef STORE_PERF_CNT_EN
   logic [31:0] r_store_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_store_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if ((r_state == StWait) && bus.data_data_ok) begin
            r_store_cnt <= r_store_cnt + 32'd1;
         end
         if (stall_o) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign perf_store_cnt = r_store_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed vector table, multi-cycle corner sequences and random stores.
module tb_mem_store_unit;

   localparam logic [7:0] OpSb  = 8'h28;
   localparam logic [7:0] OpSh  = 8'h29;
   localparam logic [7:0] OpSwl = 8'h2A;
   localparam logic [7:0] OpSw  = 8'h2B;
   localparam logic [7:0] OpSwr = 8'h2E;
   localparam logic [7:0] OpNop = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_valid;
   logic [7:0]  aluop;
   logic [31:0] addr;
   logic [31:0] rt;
   logic        exc_flush;
   logic        pipe_adv;
   logic        ades;
   logic        stall;
`ifdef STORE_PERF_CNT_EN
   logic [31:0] perf_store_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_pass     = 0;
   int n_total    = 0;
   int exp_stores = 0;

   mem_store_unit_if bus_if ();

   always #5 clk = ~clk;

   mem_store_unit dut (
      .clk           (clk),
      .rst           (rst),
      .store_valid_i (store_valid),
      .aluop_i       (aluop),
      .mem_addr_i    (addr),
      .rt_data_i     (rt),
      .exc_flush_i   (exc_flush),
      .pipe_adv_i    (pipe_adv),
      .bus           (bus_if),
      .ades_o        (ades),
      .stall_o       (stall)
`ifdef STORE_PERF_CNT_EN
      ,
      .perf_store_cnt (perf_store_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   typedef struct {
      string       nm;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] r;
      logic        e_ades;
      logic        e_legal;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [1:0]  e_size;
      logic [31:0] e_addr;
   } vec_t;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endfunction

   // Reference: expected bus fields derived from byte-count arithmetic on the address offset.
   function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r,
                                 output logic e_ades, output logic e_legal,
                                 output logic [3:0] e_strb, output logic [31:0] e_wdata,
                                 output logic [1:0] e_size, output logic [31:0] e_addr);
      int off;
      off     = int'(a[1:0]);
      e_ades  = 1'b0;
      e_legal = 1'b1;
      e_strb  = 4'h0;
      e_wdata = 32'h0;
      e_size  = 2'd2;
      e_addr  = a;
      if (op == OpSb) begin
         e_size  = 2'd0;
         e_strb  = 4'(1 << off);
         e_wdata = {24'b0, r[7:0]} * 32'h0101_0101;
      end else if (op == OpSh) begin
         e_ades  = a[0];
         e_size  = 2'd1;
         e_strb  = 4'(3 << (2 * (off / 2)));
         e_wdata = {16'b0, r[15:0]} * 32'h0001_0001;
      end else if (op == OpSw) begin
         e_ades  = (off != 0);
         e_strb  = 4'hF;
         e_wdata = r;
      end else if (op == OpSwl) begin
         e_strb  = 4'((1 << (off + 1)) - 1);
         e_wdata = r >> (8 * (3 - off));
         e_addr  = a & ~32'h3;
      end else if (op == OpSwr) begin
         e_strb  = 4'(15 << off);
         e_wdata = r << (8 * off);
         e_addr  = a & ~32'h3;
      end else begin
         e_legal = 1'b0;
      end
      if (e_ades) e_legal = 1'b0;
      if (!e_legal) begin
         e_strb  = 4'h0;
         e_wdata = 32'h0;
         e_size  = 2'd0;
         e_addr  = 32'h0;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full store from IDLE back to IDLE; slave answers addr_ok after d_ao and data_ok after d_do.
   task automatic run_store(input string nm, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] r, input int d_ao, input int d_do,
                            input logic e_ades, input logic e_legal, input logic [3:0] e_strb,
                            input logic [31:0] e_wdata, input logic [1:0] e_size,
                            input logic [31:0] e_addr);
      int stalls;
      stalls      = 0;
      store_valid = 1'b1;
      aluop       = op;
      addr        = a;
      rt          = r;
      @(negedge clk);
      chk({nm, " ades"}, ades, e_ades);
      chk({nm, " idle stall"}, {bus_if.data_req, stall}, {1'b0, e_legal});
      if (stall) stalls++;
      if (!e_legal) begin
         step();
         @(negedge clk);
         chk({nm, " no req"}, {bus_if.data_req, stall}, 2'b00);
         store_valid = 1'b0;
         step();
         return;
      end
      for (int k = 0; k <= d_ao; k++) begin
         step();
         bus_if.data_addr_ok = (k == d_ao);
         @(negedge clk);
         chk({nm, " req"}, {bus_if.data_req, bus_if.data_wr, stall}, 3'b111);
         chk({nm, " fields"},
             {bus_if.data_size, bus_if.data_addr, bus_if.data_wstrb, bus_if.data_wdata},
             {e_size, e_addr, e_strb, e_wdata});
         if (stall) stalls++;
      end
      for (int j = 0; j <= d_do; j++) begin
         step();
         bus_if.data_addr_ok = 1'b0;
         bus_if.data_data_ok = (j == d_do);
         @(negedge clk);
         chk({nm, " wait"}, {bus_if.data_req, stall}, {1'b0, j != d_do});
         if (stall) stalls++;
      end
      exp_stores++;
      step();
      bus_if.data_data_ok = 1'b0;
      pipe_adv            = 1'b1;
      store_valid         = 1'b0;
      @(negedge clk);
      chk({nm, " done"}, {bus_if.data_req, stall}, 2'b00);
      chk({nm, " stall cycles"}, stalls, 2 + d_ao + d_do);
      step();
      pipe_adv = 1'b0;
   endtask

   vec_t vecs[$];

   initial begin
      logic        m_ades;
      logic        m_legal;
      logic [3:0]  m_strb;
      logic [31:0] m_wdata;
      logic [1:0]  m_size;
      logic [31:0] m_addr;
      logic [7:0]  ops[6];

      vecs.push_back('{"sw",     OpSw,  32'h1000_0004, 32'hDEAD_BEEF, 0, 1, 4'hF, 32'hDEAD_BEEF, 2'd2, 32'h1000_0004});
      vecs.push_back('{"sb3",    OpSb,  32'h1000_0003, 32'h1234_5678, 0, 1, 4'h8, 32'h7878_7878, 2'd0, 32'h1000_0003});
      vecs.push_back('{"sb0",    OpSb,  32'h1000_0000, 32'h0000_00AB, 0, 1, 4'h1, 32'hABAB_ABAB, 2'd0, 32'h1000_0000});
      vecs.push_back('{"sh2",    OpSh,  32'h1000_0002, 32'hAAAA_5555, 0, 1, 4'hC, 32'h5555_5555, 2'd1, 32'h1000_0002});
      vecs.push_back('{"sh0",    OpSh,  32'h1000_0000, 32'h0000_BEEF, 0, 1, 4'h3, 32'hBEEF_BEEF, 2'd1, 32'h1000_0000});
      vecs.push_back('{"swl1",   OpSwl, 32'h1000_0001, 32'h1122_3344, 0, 1, 4'h3, 32'h0000_1122, 2'd2, 32'h1000_0000});
      vecs.push_back('{"swl0",   OpSwl, 32'h1000_0000, 32'h1122_3344, 0, 1, 4'h1, 32'h0000_0011, 2'd2, 32'h1000_0000});
      vecs.push_back('{"swl3",   OpSwl, 32'h1000_0003, 32'h1122_3344, 0, 1, 4'hF, 32'h1122_3344, 2'd2, 32'h1000_0000});
      vecs.push_back('{"swr2",   OpSwr, 32'h1000_0002, 32'h1122_3344, 0, 1, 4'hC, 32'h3344_0000, 2'd2, 32'h1000_0000});
      vecs.push_back('{"swr3",   OpSwr, 32'h1000_0003, 32'h1122_3344, 0, 1, 4'h8, 32'h4400_0000, 2'd2, 32'h1000_0000});
      vecs.push_back('{"swr0",   OpSwr, 32'h1000_0000, 32'h1122_3344, 0, 1, 4'hF, 32'h1122_3344, 2'd2, 32'h1000_0000});
      vecs.push_back('{"ades_sh", OpSh, 32'h1000_0001, 32'h1122_3344, 1, 0, 4'h0, 32'h0, 2'd0, 32'h0});
      vecs.push_back('{"ades_sw", OpSw, 32'h1000_0002, 32'h1122_3344, 1, 0, 4'h0, 32'h0, 2'd0, 32'h0});
      vecs.push_back('{"nonstore", OpNop, 32'h1000_0000, 32'h1122_3344, 0, 0, 4'h0, 32'h0, 2'd0, 32'h0});

      rst                 = 1'b1;
      store_valid         = 1'b0;
      aluop               = OpNop;
      addr                = 32'h0;
      rt                  = 32'h0;
      exc_flush           = 1'b0;
      pipe_adv            = 1'b0;
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset outputs",
          {bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_addr,
           bus_if.data_wstrb, bus_if.data_wdata, stall, ades}, '0);

      // Reset while the write is outstanding abandons it.
      step();
      store_valid = 1'b1; aluop = OpSw; addr = 32'h3000_0010; rt = 32'h0BAD_F00D;
      step();
      bus_if.data_addr_ok = 1'b1;
      step();
      bus_if.data_addr_ok = 1'b0;
      @(negedge clk);
      chk("rst-wait pre", {bus_if.data_req, stall}, 2'b01);
      rst = 1'b1; store_valid = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst-wait outputs",
          {bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_addr,
           bus_if.data_wstrb, bus_if.data_wdata, stall, ades}, '0);
      exp_stores = 0;

      // Stray data_ok in IDLE is ignored.
      step();
      bus_if.data_data_ok = 1'b1;
      step();
      bus_if.data_data_ok = 1'b0;
      @(negedge clk);
      chk("idle data_ok", {bus_if.data_req, stall}, 2'b00);
      step();

      foreach (vecs[i]) begin
         run_store(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].r, 0, 0, vecs[i].e_ades,
                   vecs[i].e_legal, vecs[i].e_strb, vecs[i].e_wdata, vecs[i].e_size,
                   vecs[i].e_addr);
      end

      run_store("addr_ok late", OpSb, 32'h1000_0001, 32'h0000_00C3, 3, 2, 1'b0, 1'b1, 4'h2,
                32'hC3C3_C3C3, 2'd0, 32'h1000_0001);

      // Flush in the second REQ cycle withdraws the request.
      store_valid = 1'b1; aluop = OpSw; addr = 32'h2000_0008; rt = 32'hCAFE_F00D;
      step();
      @(negedge clk);
      chk("flush req1", {bus_if.data_req, stall}, 2'b11);
      step();
      exc_flush = 1'b1;
      @(negedge clk);
      chk("flush req2", {bus_if.data_req, stall}, 2'b11);
      step();
      exc_flush = 1'b0; store_valid = 1'b0;
      @(negedge clk);
      chk("flush idle", {bus_if.data_req, stall}, 2'b00);
      step();
      @(negedge clk);
      chk("flush stays idle", bus_if.data_req, 1'b0);
      step();

      // Flush together with addr_ok still completes; then hold DONE with pipe_adv low.
      store_valid = 1'b1; aluop = OpSh; addr = 32'h2000_0006; rt = 32'h0000_1234;
      step();
      exc_flush = 1'b1; bus_if.data_addr_ok = 1'b1;
      @(negedge clk);
      chk("flush+ack req", {bus_if.data_req, stall, bus_if.data_wstrb}, 6'b11_1100);
      step();
      bus_if.data_addr_ok = 1'b0;
      @(negedge clk);
      chk("flush+ack wait", {bus_if.data_req, stall}, 2'b01);
      step();
      @(negedge clk);
      chk("wait ignores flush", {bus_if.data_req, stall}, 2'b01);
      step();
      exc_flush = 1'b0; bus_if.data_data_ok = 1'b1;
      @(negedge clk);
      chk("flush+ack data_ok", {bus_if.data_req, stall}, 2'b00);
      exp_stores++;
      for (int k = 0; k < 4; k++) begin
         step();
         bus_if.data_data_ok = 1'b0;
         @(negedge clk);
         chk("done hold", {bus_if.data_req, stall}, 2'b00);
      end
      pipe_adv = 1'b1; store_valid = 1'b0;
      step();
      pipe_adv = 1'b0;
      @(negedge clk);
      chk("done exit", {bus_if.data_req, stall}, 2'b00);
      step();

      ops = '{OpSb, OpSh, OpSw, OpSwl, OpSwr, OpNop};
      for (int t = 0; t < 150; t++) begin
         logic [7:0]  op;
         logic [31:0] a;
         logic [31:0] r;
         op = ops[$urandom_range(0, 5)];
         a  = $urandom;
         r  = $urandom;
         model(op, a, r, m_ades, m_legal, m_strb, m_wdata, m_size, m_addr);
         run_store("rand", op, a, r, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   m_ades, m_legal, m_strb, m_wdata, m_size, m_addr);
      end

`ifdef STORE_PERF_CNT_EN
      chk("perf store cnt", perf_store_cnt, exp_stores);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
